// File: rtl/uart_rx.sv
// UART receive deserialiser.
// Oversamples the rx line on the 16x baud_en tick, qualifies the start bit at
// mid-bit, then samples data, optional parity and stop at the centre of each
// bit. Each completed frame produces 1-clk result pulses and updates rx_data_o.
module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  baud_en_i,
  input  logic                  rx_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  rx_busy_o
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Mid start bit is half a bit after the falling edge; later bits are a full
  // bit period apart, which keeps every sample near the bit centre.
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  state_t                 state_reg;
  logic [TICK_W-1:0]      tick_reg;
  logic [IDX_W-1:0]       bit_idx_reg;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic                   par_en_reg;
  logic                   par_odd_reg;
  logic                   par_err_reg;

  // Metastability synchroniser for the asynchronous rx line; resets to idle-high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // Frame FSM: advances only on baud ticks; result pulses self-clear every clk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      tick_reg     <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      par_err_reg  <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;

      if (baud_en_i) begin
        unique case (state_reg)
          IDLE: begin
            if (!rx_s) begin
              state_reg   <= START;
              tick_reg    <= '0;
              // Frame format is frozen for the whole frame.
              par_en_reg  <= parity_en_i;
              par_odd_reg <= parity_odd_i;
              par_err_reg <= 1'b0;
            end
          end

          START: begin
            if (tick_reg == TICK_HALF) begin
              if (!rx_s) begin
                state_reg   <= DATA;
                tick_reg    <= '0;
                bit_idx_reg <= '0;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state_reg <= IDLE;
              end
            end else begin
              tick_reg <= tick_reg + 1'b1;
            end
          end

          DATA: begin
            if (tick_reg == TICK_LAST) begin
              tick_reg    <= '0;
              // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
              shift_reg   <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
              bit_idx_reg <= bit_idx_reg + 1'b1;
              if (bit_idx_reg == IDX_LAST) begin
                state_reg <= par_en_reg ? PARITY : STOP;
              end
            end else begin
              tick_reg <= tick_reg + 1'b1;
            end
          end

          PARITY: begin
            if (tick_reg == TICK_LAST) begin
              tick_reg    <= '0;
              par_err_reg <= (^shift_reg) ^ rx_s ^ par_odd_reg;
              state_reg   <= STOP;
            end else begin
              tick_reg <= tick_reg + 1'b1;
            end
          end

          STOP: begin
            if (tick_reg == TICK_LAST) begin
              tick_reg     <= '0;
              rx_data_o    <= shift_reg;
              rx_valid_o   <= rx_s;
              frame_err_o  <= !rx_s;
              parity_err_o <= par_err_reg;
              // Return immediately at mid stop bit so back-to-back frames work.
              state_reg    <= IDLE;
            end else begin
              tick_reg <= tick_reg + 1'b1;
            end
          end

          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign rx_busy_o = (state_reg != IDLE);

endmodule
